virtio_avail_poller: RTL and testbench
======================================

# virtio_avail_poller

Hardware replacement for the notify/avail-ring polling stages of the virtio DMA path: latches per-queue notifications from the virtio CSR block, round-robin selects a pending queue, reads the driver's `avail.idx` from host memory through a read-request port, and emits a `{qid, start_idx, count}` record to the downstream descriptor-fetch stage. Sits between the virtio CSR (queue_notify writes) and the descriptor fetcher; owns the per-queue `next_avail_idx` for 3 queues.

## Interface
- `NQ`, 3: number of virtqueues (qid width fixed at 2).
- `AW`, 64: host address width.
- `clk` in 1: block clock, same as CSR clock.
- `csr_rst` in 1: synchronous active-high reset.
- `notify_valid` in 1: one-cycle pulse, queue_notify written.
- `notify_qid` in 2: queue index of the notify; values ≥ NQ ignored.
- `queue_ready` in NQ: per-queue enable from CSR.
- `avail_addr` in NQ*AW: per-queue avail-ring base, queue i at bits [i*AW +: AW].
- `queue_size` in NQ*16: per-queue ring size.
- `rd_req_valid` out 1, `rd_req_ready` in 1, `rd_req_addr` out AW: host read request, 2 bytes.
- `rd_rsp_valid` in 1, `rd_rsp_data` in 16: read response, always accepted.
- `avail_valid` out 1, `avail_ready` in 1: downstream record handshake.
- `avail_qid` out 2, `avail_start_idx` out 16, `avail_count` out 16: record fields.
- `err_valid` out 1: one-cycle pulse, bad avail index (see Configuration).
- `err_qid` out 2: queue of the error.

## Operation
- `pending[i]` set by `notify_valid && notify_qid==i && queue_ready[i]`; cleared when arbiter grants queue i. Set wins over clear in the same cycle (notify during own grant cycle is not lost).
- `queue_ready[i]==0`: `pending[i]` forced 0, `next_avail_idx[i]` forced 0, grant never issued to i.
- FSM: IDLE → ARB → REQ → WAIT → (EMIT | IDLE) → IDLE.
  - IDLE: if any pending, go ARB.
  - ARB: round-robin grant starting after `last_qid`; latch `cur_qid`, clear its pending, go REQ.
  - REQ: `rd_req_valid=1`, `rd_req_addr = avail_addr[cur_qid] + 2`; hold until `rd_req_ready`, go WAIT.
  - WAIT: on `rd_rsp_valid` compute `count = rd_rsp_data - next_avail_idx[cur_qid]` mod 2^16; count 0 → IDLE; else EMIT.
  - EMIT: `avail_valid=1` with `start_idx = next_avail_idx[cur_qid]`; on `avail_ready`, `next_avail_idx[cur_qid] <= rd_rsp_data` (latched), go IDLE.
- Address add is AW-bit, wraps silently.
- `queue_ready[cur_qid]` dropping in REQ/WAIT/EMIT: finish the read handshake, discard the record, go IDLE; no emit.

## Timing
- Reset values: `rd_req_valid=0`, `rd_req_addr=0`, `avail_valid=0`, `avail_*=0`, `err_valid=0`, `err_qid=0`, all pending 0, all next idx 0, `last_qid=NQ-1`, FSM IDLE.
- Notify to `rd_req_valid`: 3 cycles (pending reg, IDLE, ARB) with FSM idle.
- `rd_rsp_valid` to `avail_valid`: 1 cycle.
- Outputs registered; `avail_*` and `rd_req_addr` stable while valid and not ready.
- One outstanding read at a time; `rd_rsp_valid` outside WAIT ignored.
- Reset mid-operation: all state to reset values next edge; outstanding response discarded.

## Configuration
- `VIRTIO_AVAIL_ERRCHK_EN` defined: in WAIT, `count > queue_size[cur_qid]` → `err_valid` pulse 1 cycle with `err_qid=cur_qid`, no emit, `next_avail_idx` unchanged, go IDLE.
- Undefined: no check, `err_valid`/`err_qid` tied 0; any nonzero count emitted.

## Test plan
- Reset, all queues ready, notify q1, rsp 0x0004 → rd_req_addr=avail_addr[1]+2, record {1, 0, 4}; next notify q1 rsp 0x0006 → {1, 4, 2}.
- Wrap: next_avail_idx q0 = 0xFFFE, rsp 0x0001 → {0, 0xFFFE, 3}.
- Notify q0, q1, q2 same window, avail_ready held 0 for 5 cycles → records in order q0, q1, q2; fields stable while stalled.
- Notify q2 during its ARB cycle → q2 serviced twice; rsp equal to next idx on second → no record.
- queue_size=8, rsp count 9 with ERRCHK_EN → err_valid 1 cycle, err_qid correct, no record; without macro → record count 9.
- csr_rst asserted in WAIT → all outputs 0 next cycle, late rsp ignored, next notify serviced normally.

Source files
------------

// File: rtl/virtio_avail_poller.sv
// virtio_avail_poller: latches per-queue virtio notifications, round-robin
// selects a pending queue, reads the driver's avail.idx (2 bytes at
// avail_addr + 2) from host memory, and emits {qid, start_idx, count}
// records to the descriptor-fetch stage. Owns next_avail_idx per queue.
//
// Optional build macro VIRTIO_AVAIL_ERRCHK_EN: when defined, a response
// whose count exceeds queue_size raises a one-cycle err_valid pulse instead
// of emitting a record. When undefined, err_valid/err_qid are tied to 0.
module virtio_avail_poller #(
   parameter int NQ = 3,
   parameter int AW = 64
) (
   input  logic             clk,
   input  logic             csr_rst,
   input  logic             notify_valid,
   input  logic [1:0]       notify_qid,
   input  logic [NQ-1:0]    queue_ready,
   input  logic [NQ*AW-1:0] avail_addr,
   input  logic [NQ*16-1:0] queue_size,
   output logic             rd_req_valid,
   input  logic             rd_req_ready,
   output logic [AW-1:0]    rd_req_addr,
   input  logic             rd_rsp_valid,
   input  logic [15:0]      rd_rsp_data,
   output logic             avail_valid,
   input  logic             avail_ready,
   output logic [1:0]       avail_qid,
   output logic [15:0]      avail_start_idx,
   output logic [15:0]      avail_count,
   output logic             err_valid,
   output logic [1:0]       err_qid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_REQ,
      S_WAIT,
      S_EMIT
   } state_t;

   state_t      state;
   logic [NQ-1:0] pending;
   logic [NQ-1:0] eligible;
   logic [NQ-1:0] notify_set;
   logic [15:0] next_idx [NQ];
   logic [1:0]  last_qid;
   logic [1:0]  cur_qid;
   logic [15:0] rsp_hold;

   logic        grant_found;
   logic [1:0]  grant_qid;
   logic [AW-1:0] grant_addr;
   logic [15:0] cur_idx;
   logic        cur_ready;
   logic [15:0] rsp_count;
   logic        err_hit;
   logic        commit;

   // Queue index k steps after base, wrapping modulo NQ.
   function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
      rr_idx = 2'((int'(base) + k) % NQ);
   endfunction

   assign eligible   = pending & queue_ready;
   assign cur_idx    = next_idx[cur_qid];
   assign cur_ready  = queue_ready[cur_qid];
   assign rsp_count  = rd_rsp_data - cur_idx;
   assign grant_addr = avail_addr[int'(grant_qid)*AW +: AW] + AW'(2);
   assign commit     = (state == S_EMIT) && avail_ready && cur_ready;

   // Decode which queue (if any) the current notify targets.
   always_comb begin
      notify_set = '0;
      for (int i = 0; i < NQ; i++) begin
         notify_set[i] = notify_valid && (notify_qid == 2'(i)) && queue_ready[i];
      end
   end

   // Round-robin pick: first eligible queue after the last one granted.
   always_comb begin
      grant_found = 1'b0;
      grant_qid   = last_qid;
      for (int k = 1; k <= NQ; k++) begin
         if (!grant_found && eligible[rr_idx(last_qid, k)]) begin
            grant_found = 1'b1;
            grant_qid   = rr_idx(last_qid, k);
         end
      end
   end

`ifdef VIRTIO_AVAIL_ERRCHK_EN
   logic [15:0] cur_size;
   assign cur_size = queue_size[int'(cur_qid)*16 +: 16];
   assign err_hit  = (rsp_count > cur_size);

   // One-cycle error pulse for an avail index that runs past the ring size.
   always_ff @(posedge clk) begin
      if (csr_rst) begin
         err_valid <= 1'b0;
         err_qid   <= '0;
      end else begin
         err_valid <= 1'b0;
         if (state == S_WAIT && rd_rsp_valid && cur_ready && err_hit) begin
            err_valid <= 1'b1;
            err_qid   <= cur_qid;
         end
      end
   end
`else
   logic unused_queue_size;
   assign unused_queue_size = ^queue_size;
   assign err_hit   = 1'b0;
   assign err_valid = 1'b0;
   assign err_qid   = '0;
`endif

   // Pending flags: a notify in the grant cycle wins over the grant's clear.
   always_ff @(posedge clk) begin
      if (csr_rst) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < NQ; i++) begin
            if (!queue_ready[i]) begin
               pending[i] <= 1'b0;
            end else if (notify_set[i]) begin
               pending[i] <= 1'b1;
            end else if (state == S_ARB && grant_found && grant_qid == 2'(i)) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // Per-queue next_avail_idx, advanced only when a record is accepted.
   always_ff @(posedge clk) begin
      if (csr_rst) begin
         for (int i = 0; i < NQ; i++) next_idx[i] <= '0;
      end else begin
         for (int i = 0; i < NQ; i++) begin
            if (!queue_ready[i]) begin
               next_idx[i] <= '0;
            end else if (commit && cur_qid == 2'(i)) begin
               next_idx[i] <= rsp_hold;
            end
         end
      end
   end

   // Holds the returned avail.idx until the record is accepted downstream.
   always_ff @(posedge clk) begin
      if (state == S_WAIT && rd_rsp_valid) begin
         rsp_hold <= rd_rsp_data;
      end
   end

   // Main sequencer: arbitrate, issue the read, then emit or drop the record.
   always_ff @(posedge clk) begin
      if (csr_rst) begin
         state           <= S_IDLE;
         last_qid        <= 2'(NQ - 1);
         cur_qid         <= '0;
         rd_req_valid    <= 1'b0;
         rd_req_addr     <= '0;
         avail_valid     <= 1'b0;
         avail_qid       <= '0;
         avail_start_idx <= '0;
         avail_count     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|eligible) state <= S_ARB;
            end
            S_ARB: begin
               if (grant_found) begin
                  cur_qid      <= grant_qid;
                  last_qid     <= grant_qid;
                  rd_req_valid <= 1'b1;
                  rd_req_addr  <= grant_addr;
                  state        <= S_REQ;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_REQ: begin
               // The read handshake completes even if the queue was disabled.
               if (rd_req_ready) begin
                  rd_req_valid <= 1'b0;
                  state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rd_rsp_valid) begin
                  if (!cur_ready || rsp_count == 16'd0 || err_hit) begin
                     state <= S_IDLE;
                  end else begin
                     avail_valid     <= 1'b1;
                     avail_qid       <= cur_qid;
                     avail_start_idx <= cur_idx;
                     avail_count     <= rsp_count;
                     state           <= S_EMIT;
                  end
               end
            end
            S_EMIT: begin
               if (!cur_ready || avail_ready) begin
                  avail_valid <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_virtio_avail_poller.sv
// Directed bench for virtio_avail_poller: a vector table of single-queue
// transactions plus hand-written multi-queue, re-notify and reset sequences.
module tb_virtio_avail_poller;
   localparam int NQ = 3;
   localparam int AW = 64;

   logic             clk = 1'b0;
   logic             csr_rst;
   logic             notify_valid;
   logic [1:0]       notify_qid;
   logic [NQ-1:0]    queue_ready;
   logic [NQ*AW-1:0] avail_addr;
   logic [NQ*16-1:0] queue_size;
   logic             rd_req_valid;
   logic             rd_req_ready;
   logic [AW-1:0]    rd_req_addr;
   logic             rd_rsp_valid;
   logic [15:0]      rd_rsp_data;
   logic             avail_valid;
   logic             avail_ready;
   logic [1:0]       avail_qid;
   logic [15:0]      avail_start_idx;
   logic [15:0]      avail_count;
   logic             err_valid;
   logic [1:0]       err_qid;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] base [NQ];

   virtio_avail_poller #(.NQ(NQ), .AW(AW)) dut (
      .clk(clk), .csr_rst(csr_rst),
      .notify_valid(notify_valid), .notify_qid(notify_qid),
      .queue_ready(queue_ready), .avail_addr(avail_addr), .queue_size(queue_size),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
      .avail_valid(avail_valid), .avail_ready(avail_ready),
      .avail_qid(avail_qid), .avail_start_idx(avail_start_idx), .avail_count(avail_count),
      .err_valid(err_valid), .err_qid(err_qid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  qid;
      logic [15:0] rsp;
      bit          rec;
      bit          err;
      logic [15:0] st;
      logic [15:0] cnt;
      int          stall;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic notify(input logic [1:0] q);
      @(negedge clk);
      notify_valid = 1'b1;
      notify_qid   = q;
   endtask

   task automatic check_record(input string tag, input logic [1:0] q,
                               input logic [15:0] st, input logic [15:0] cnt);
      chk({tag, ".avail_valid"}, 64'(avail_valid), 64'd1);
      chk({tag, ".avail_qid"}, 64'(avail_qid), 64'(q));
      chk({tag, ".start_idx"}, 64'(avail_start_idx), 64'(st));
      chk({tag, ".count"}, 64'(avail_count), 64'(cnt));
   endtask

   // Waits for the read request, completes it, returns rsp and checks outcome.
   task automatic service(input string tag, input logic [1:0] q, input logic [15:0] rsp,
                          input bit rec, input bit err, input logic [15:0] st,
                          input logic [15:0] cnt, input int stall, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         notify_valid = 1'b0;
         lat++;
      end while (!rd_req_valid && lat < 30);
      chk({tag, ".rd_req_valid"}, 64'(rd_req_valid), 64'd1);
      if (!rd_req_valid) return;
      chk({tag, ".rd_req_addr"}, rd_req_addr, base[q] + 64'd2);
      @(negedge clk);
      chk({tag, ".rd_req_hold"}, rd_req_addr, base[q] + 64'd2);
      rd_req_ready = 1'b1;
      @(negedge clk);
      rd_req_ready = 1'b0;
      chk({tag, ".rd_req_done"}, 64'(rd_req_valid), 64'd0);
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rsp;
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      chk({tag, ".err_valid"}, 64'(err_valid), 64'(err));
      if (err) chk({tag, ".err_qid"}, 64'(err_qid), 64'(q));
      if (rec) begin
         check_record(tag, q, st, cnt);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_record({tag, ".stall"}, q, st, cnt);
         end
         avail_ready = 1'b1;
         @(negedge clk);
         avail_ready = 1'b0;
         chk({tag, ".avail_done"}, 64'(avail_valid), 64'd0);
      end else begin
         chk({tag, ".no_record"}, 64'(avail_valid), 64'd0);
         @(negedge clk);
         chk({tag, ".err_pulse_end"}, 64'(err_valid), 64'd0);
         chk({tag, ".no_record_late"}, 64'(avail_valid), 64'd0);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, ".rd_req_valid"}, 64'(rd_req_valid), 64'd0);
      chk({tag, ".rd_req_addr"}, rd_req_addr, 64'd0);
      chk({tag, ".avail_valid"}, 64'(avail_valid), 64'd0);
      chk({tag, ".avail_qid"}, 64'(avail_qid), 64'd0);
      chk({tag, ".avail_start"}, 64'(avail_start_idx), 64'd0);
      chk({tag, ".avail_count"}, 64'(avail_count), 64'd0);
      chk({tag, ".err_valid"}, 64'(err_valid), 64'd0);
      chk({tag, ".err_qid"}, 64'(err_qid), 64'd0);
   endtask

   initial begin
      int lat;
      base[0] = 64'h0000_0000_1000_0000;
      base[1] = 64'h0000_0001_0000_2000;
      base[2] = 64'hFFFF_FFFF_FFFF_FFFF;   // +2 wraps to 0x1
      avail_addr   = {base[2], base[1], base[0]};
      queue_size   = {16'h0008, 16'h0100, 16'hFFFF};
      queue_ready  = 3'b111;
      csr_rst      = 1'b1;
      notify_valid = 1'b0;
      notify_qid   = 2'd0;
      rd_req_ready = 1'b0;
      rd_rsp_valid = 1'b0;
      rd_rsp_data  = 16'h0;
      avail_ready  = 1'b0;

      //           qid  rsp       rec   err   start     count     stall
      vecs[0] = '{2'd1, 16'h0004, 1'b1, 1'b0, 16'h0000, 16'h0004, 0};
      vecs[1] = '{2'd1, 16'h0006, 1'b1, 1'b0, 16'h0004, 16'h0002, 1};
      vecs[2] = '{2'd0, 16'hFFFE, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 0};
      vecs[3] = '{2'd0, 16'h0001, 1'b1, 1'b0, 16'hFFFE, 16'h0003, 0};
      vecs[4] = '{2'd2, 16'h0005, 1'b1, 1'b0, 16'h0000, 16'h0005, 0};
      vecs[5] = '{2'd2, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 0};
`ifdef VIRTIO_AVAIL_ERRCHK_EN
      vecs[6] = '{2'd2, 16'h000E, 1'b0, 1'b1, 16'h0000, 16'h0000, 0};
      vecs[7] = '{2'd2, 16'h0007, 1'b1, 1'b0, 16'h0005, 16'h0002, 0};
`else
      vecs[6] = '{2'd2, 16'h000E, 1'b1, 1'b0, 16'h0005, 16'h0009, 0};
      vecs[7] = '{2'd2, 16'h0007, 1'b1, 1'b0, 16'h000E, 16'hFFF9, 0};
`endif

      repeat (3) @(negedge clk);
      csr_rst = 1'b0;
      check_outputs_zero("reset");

      // Table of single-queue transactions, each from an idle FSM.
      for (int v = 0; v < 8; v++) begin
         notify(vecs[v].qid);
         service($sformatf("vec%0d", v), vecs[v].qid, vecs[v].rsp, vecs[v].rec,
                 vecs[v].err, vecs[v].st, vecs[v].cnt, vecs[v].stall, lat);
         chk($sformatf("vec%0d.latency", v), 64'(lat), 64'd3);
      end

      // Three notifies back to back, stalled downstream: serviced q0, q1, q2.
      @(negedge clk); notify_valid = 1'b1; notify_qid = 2'd0;
      @(negedge clk); notify_qid = 2'd1;
      @(negedge clk); notify_qid = 2'd2;
      service("rr_q0", 2'd0, 16'h0003, 1'b1, 1'b0, 16'h0001, 16'h0002, 5, lat);
      service("rr_q1", 2'd1, 16'h0008, 1'b1, 1'b0, 16'h0006, 16'h0002, 5, lat);
      service("rr_q2", 2'd2, 16'h0009, 1'b1, 1'b0, 16'h0007, 16'h0002, 5, lat);

      // Re-notify q2 on its grant edge: serviced again, second finds nothing new.
      notify(2'd2);
      @(negedge clk); notify_valid = 1'b0;
      @(negedge clk); notify_valid = 1'b1; notify_qid = 2'd2;
      service("renotify1", 2'd2, 16'h000A, 1'b1, 1'b0, 16'h0009, 16'h0001, 0, lat);
      service("renotify2", 2'd2, 16'h000A, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, lat);

      // Reset while waiting for the response; late response must be ignored.
      notify(2'd1);
      lat = 0;
      do begin
         @(negedge clk);
         notify_valid = 1'b0;
         lat++;
      end while (!rd_req_valid && lat < 30);
      chk("rst.rd_req_valid", 64'(rd_req_valid), 64'd1);
      rd_req_ready = 1'b1;
      @(negedge clk);
      rd_req_ready = 1'b0;
      csr_rst = 1'b1;
      @(negedge clk);
      csr_rst = 1'b0;
      check_outputs_zero("rst_wait");
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = 16'h0010;
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      chk("rst.late_rsp_avail", 64'(avail_valid), 64'd0);
      @(negedge clk);
      chk("rst.late_rsp_req", 64'(rd_req_valid), 64'd0);
      notify(2'd1);
      service("post_rst", 2'd1, 16'h0003, 1'b1, 1'b0, 16'h0000, 16'h0003, 0, lat);
      chk("post_rst.latency", 64'(lat), 64'd3);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
